ram_access_ctrl: RTL and testbench

- Access sequencer that drives the address, data and write-enable ports of the 32x4 synchronous RAM (ram32x4) from switch/key inputs.
- Modes: single manual write, automatic fill of all 32 words, and a free-running read scan that steps the address for the display stage.
- Sits directly upstream of ram32x4. The RAM's q output goes straight to the seven-segment decoders; this block does not consume it.

---
 rtl/ram_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// Access sequencer for the ram32x4 RAM: manual write, full-memory fill and timed read scan.
// Optional FILL_PATTERN_EN: fill writes (fill value + address) instead of a constant.
module ram_access_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4,
  parameter int SCAN_DIV = 50000000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_req,
  input  logic              fill_req,
  input  logic              scan_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              fill_done
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL, S_SCAN} state_e;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);

`ifdef FILL_PATTERN_EN
  localparam bit PATTERN_EN = 1'b1;
`else
  localparam bit PATTERN_EN = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] fill_word(input logic [DATA_W-1:0] val,
                                                  input logic [ADDR_W-1:0] addr);
    return PATTERN_EN ? val + DATA_W'(addr) : val;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic              busy_q, busy_d;
  logic              fill_done_q, fill_done_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [2:0]        wr_sync_q, wr_sync_d;
  logic [2:0]        fill_sync_q, fill_sync_d;
  logic              wr_rise, fill_rise, can_start;

  // Bits [1:0] synchronise the raw level; bit 2 is the previous value for edge detection.
  assign wr_rise   = wr_sync_q[1] & ~wr_sync_q[2];
  assign fill_rise = fill_sync_q[1] & ~fill_sync_q[2];
  assign can_start = (state_q == S_IDLE) || (state_q == S_SCAN);

  always_comb begin
    state_d       = state_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    busy_d        = 1'b0;
    fill_done_d   = 1'b0;
    fill_val_d    = fill_val_q;
    div_d         = div_q;
    wr_sync_d     = {wr_sync_q[1:0], wr_req};
    fill_sync_d   = {fill_sync_q[1:0], fill_req};

    if (can_start && fill_rise) begin
      state_d       = S_FILL;
      fill_val_d    = data_in;
      ram_address_d = '0;
      ram_data_d    = fill_word(data_in, '0);
      ram_wren_d    = 1'b1;
      busy_d        = 1'b1;
    end else if (can_start && wr_rise) begin
      state_d       = S_WRITE;
      ram_address_d = addr_in;
      ram_data_d    = data_in;
      ram_wren_d    = 1'b1;
      busy_d        = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (scan_en) begin
            state_d       = S_SCAN;
            ram_address_d = '0;
            div_d         = '0;
          end else begin
            ram_address_d = addr_in;
            ram_data_d    = data_in;
          end
        end
        S_WRITE: begin
          state_d       = S_IDLE;
          ram_address_d = addr_in;
          ram_data_d    = data_in;
        end
        S_FILL: begin
          // Request edges are ignored here; the sync chain keeps shifting so they are lost.
          if (ram_address_q == ADDR_LAST) begin
            state_d       = S_IDLE;
            fill_done_d   = 1'b1;
            ram_address_d = addr_in;
            ram_data_d    = data_in;
          end else begin
            ram_address_d = ram_address_q + ADDR_W'(1);
            ram_data_d    = fill_word(fill_val_q, ram_address_q + ADDR_W'(1));
            ram_wren_d    = 1'b1;
            busy_d        = 1'b1;
          end
        end
        S_SCAN: begin
          if (!scan_en) begin
            state_d       = S_IDLE;
            ram_address_d = addr_in;
            ram_data_d    = data_in;
          end else if (div_q == DIV_LAST) begin
            div_d         = '0;
            ram_address_d = ram_address_q + ADDR_W'(1);
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      busy_q        <= 1'b0;
      fill_done_q   <= 1'b0;
      fill_val_q    <= '0;
      div_q         <= '0;
      wr_sync_q     <= '0;
      fill_sync_q   <= '0;
    end else begin
      state_q       <= state_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      busy_q        <= busy_d;
      fill_done_q   <= fill_done_d;
      fill_val_q    <= fill_val_d;
      div_q         <= div_d;
      wr_sync_q     <= wr_sync_d;
      fill_sync_q   <= fill_sync_d;
    end
  end

  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign busy        = busy_q;
  assign fill_done   = fill_done_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: expected RAM writes are queued by the stimulus and
// popped by a monitor whenever the DUT asserts ram_wren; a local RAM model supports readback.
module tb_ram_access_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic [4:0] addr_in;
  logic [3:0] data_in;
  logic       wr_req, fill_req, scan_en;
  logic [4:0] ram_address;
  logic [3:0] ram_data;
  logic       ram_wren, busy, fill_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0] a;
    logic [3:0] d;
  } wr_t;
  wr_t        exp_q[$];
  logic [3:0] mem[32];

  ram_access_ctrl #(.ADDR_W(5), .DATA_W(4), .SCAN_DIV(4)) dut (
    .clock(clock), .resetn(resetn), .addr_in(addr_in), .data_in(data_in),
    .wr_req(wr_req), .fill_req(fill_req), .scan_en(scan_en),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .busy(busy), .fill_done(fill_done)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] fexp(input logic [3:0] v, input int a);
`ifdef FILL_PATTERN_EN
    return 4'((int'(v) + a) % 16);
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: every write the DUT issues must match the head of the expected queue.
  always @(negedge clock) begin
    if (ram_wren) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0d, expected no write", ram_address, ram_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (ram_address !== e.a || ram_data !== e.d) begin
          n_fail++;
          $display("FAIL write: addr %0d data %0d, expected addr %0d data %0d",
                   ram_address, ram_data, e.a, e.d);
        end
      end
      mem[ram_address] = ram_data;
    end
  end

  // Fill with value v; abort_at < 32 asserts reset while that address is presented.
  task automatic run_fill(input logic [3:0] v, input int abort_at, input bit both);
    int n;
    n = (abort_at < 32) ? abort_at : 32;
    data_in = v;
    addr_in = 5'd2;
    fill_req = 1'b1;
    if (both) wr_req = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back('{a: 5'(i), d: fexp(v, i)});
    tick(2);
    chk("fill_not_yet_busy", busy, 0);
    tick(1);
    chk("fill_busy_start", busy, 1);
    for (int i = 0; i < 32; i++) begin
      if (i == abort_at) begin
        resetn = 1'b0;
        fill_req = 1'b0;
        wr_req = 1'b0;
        #1;
        chk("abort_wren", ram_wren, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", ram_address, 0);
        tick(2);
        resetn = 1'b1;
        tick(2);
        return;
      end
      chk("fill_addr", ram_address, i);
      chk("fill_wren", ram_wren, 1);
      if (i == 10 && !both) wr_req = 1'b1;
      tick(1);
    end
    chk("fill_done_pulse", fill_done, 1);
    chk("fill_busy_end", busy, 0);
    chk("fill_wren_end", ram_wren, 0);
    tick(1);
    chk("fill_done_clear", fill_done, 0);
    fill_req = 1'b0;
    wr_req = 1'b0;
    tick(3);
  endtask

  initial begin
    resetn = 1'b0;
    addr_in = '0; data_in = '0; wr_req = 1'b0; fill_req = 1'b0; scan_en = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 4'hx;

    // Reset held with inputs toggling: outputs stay zero.
    for (int k = 0; k < 4; k++) begin
      addr_in = 5'($urandom); data_in = 4'($urandom);
      wr_req = 1'($urandom); fill_req = 1'($urandom); scan_en = 1'($urandom);
      tick(1);
      chk("rst_addr", ram_address, 0);
      chk("rst_data", ram_data, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", fill_done, 0);
    end
    wr_req = 1'b0; fill_req = 1'b0; scan_en = 1'b0;
    addr_in = 5'd7; data_in = 4'h5;
    resetn = 1'b1;
    tick(1);
    chk("idle_follow_addr", ram_address, 7);
    chk("idle_follow_data", ram_data, 5);

    // Manual write, level held 10 cycles.
    addr_in = 5'd9; data_in = 4'hA;
    exp_q.push_back('{a: 5'd9, d: 4'hA});
    wr_req = 1'b1;
    tick(2);
    chk("wr_latency_early", ram_wren, 0);
    tick(1);
    chk("wr_wren", ram_wren, 1);
    chk("wr_busy", busy, 1);
    chk("wr_addr", ram_address, 9);
    chk("wr_data", ram_data, 10);
    tick(1);
    chk("wr_one_cycle", ram_wren, 0);
    tick(6);
    wr_req = 1'b0;
    tick(2);
    chk("wr_readback", mem[9], 10);

    // Full fill with a wr_req edge in the middle.
    run_fill(4'h3, 99, 1'b0);
    for (int i = 0; i < 32; i++) chk("fill3_readback", mem[i], fexp(4'h3, i));

    // Fill aborted by reset while address 12 is presented.
    run_fill(4'h7, 12, 1'b0);
    for (int i = 0; i < 32; i++)
      chk("abort_readback", mem[i], (i < 12) ? fexp(4'h7, i) : fexp(4'h3, i));
    chk("abort_queue_empty", exp_q.size(), 0);

    // Simultaneous wr and fill edges: fill wins, write dropped.
    run_fill(4'h5, 99, 1'b1);
    for (int i = 0; i < 32; i++) chk("prio_readback", mem[i], fexp(4'h5, i));

    // Scan with SCAN_DIV=4: one address step every 4 cycles, wrapping at 31.
    addr_in = 5'd21;
    scan_en = 1'b1;
    tick(1);
    for (int k = 0; k < 132; k++) begin
      chk("scan_addr", ram_address, (k / 4) % 32);
      tick(1);
    end
    chk("scan_busy", busy, 0);
    scan_en = 1'b0;
    tick(1);
    chk("scan_exit_addr", ram_address, 21);

    tick(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
